// File: rtl/s1_fetch_pkg.sv
// Shared constants, state encoding and region decode
// for the stage-1 fetch unit.
package s1_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;
   localparam logic [31:0] NOP_DEF      = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_BOOT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_REDIRECT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_BIOS = 2'd1,
      SRC_IMEM = 2'd2
   } src_e;

   // BIOS wins on pc[30]; IMEM lives at pc[31:28]=0001.
   function automatic src_e pc_region(logic [3:0] top);
      if (top[2])
         return SRC_BIOS;
      else if (top == 4'b0001)
         return SRC_IMEM;
      else
         return SRC_NONE;
   endfunction

endpackage

// File: rtl/s1_fetch_perf_counters.sv
// Cycle and retired-instruction counters with
// synchronous clear taking priority over increment.
import s1_fetch_pkg::*;

module s1_fetch_perf_counters (
   input  logic        clk,
   input  logic        rst,
   input  logic        counter_rst_i,
   input  logic        instr_inc_i,
   output logic [31:0] cycle_cnt_o,
   output logic [31:0] instr_cnt_o
);

   logic [31:0] cycle_q, cycle_d;
   logic [31:0] instr_q, instr_d;

   // Next-count: clear beats increment, both wrap.
   always_comb begin
      cycle_d = cycle_q + 32'd1;
      instr_d = instr_q;
      if (instr_inc_i)
         instr_d = instr_q + 32'd1;
      if (counter_rst_i) begin
         cycle_d = '0;
         instr_d = '0;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_q <= '0;
         instr_q <= '0;
      end else begin
         cycle_q <= cycle_d;
         instr_q <= instr_d;
      end
   end

   assign cycle_cnt_o = cycle_q;
   assign instr_cnt_o = instr_q;

endmodule

// File: rtl/s1_fetch.sv
// Stage-1 fetch: PC, memory address generation,
// registered redirect and the stage-2 instruction slot.
import s1_fetch_pkg::*;

module s1_fetch #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter logic [31:0] NOP      = NOP_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic [31:0] bios_dout,
   input  logic [31:0] imem_dout,
   input  logic        counter_rst,
   output logic [31:0] fetch_addr,
   output logic [11:0] bios_addra,
   output logic [13:0] imem_addrb,
   output logic [31:0] instruction_s2,
   output logic [31:0] pc_s2,
   output logic        valid_s2,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] target_q, target_d;
   logic [31:0] addr;
   logic [31:0] instr;
   logic        vld;
   src_e        src;

   assign src = pc_region(pc_q[31:28]);

   // Fetch FSM next-state, address and slot contents.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      target_d = target_q;
      addr     = RESET_PC;
      instr    = NOP;
      vld      = 1'b0;
      unique case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            addr = stall ? pc_q : pc_q + 32'd4;
            pc_d = addr;
            unique case (src)
               SRC_BIOS: begin
                  instr = bios_dout;
                  vld   = 1'b1;
               end
               SRC_IMEM: begin
                  instr = imem_dout;
                  vld   = 1'b1;
               end
               default: begin
                  instr = NOP;
                  vld   = 1'b0;
               end
            endcase
            if (redirect && !stall) begin
               target_d = redirect_target & ~32'd3;
               state_d  = ST_REDIRECT;
            end
         end
         ST_REDIRECT: begin
            addr = target_q;
            if (!stall) begin
               pc_d    = target_q;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // Fetch state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         target_q <= target_d;
      end
   end

   assign fetch_addr     = addr;
   assign bios_addra     = addr[13:2];
   assign imem_addrb     = addr[15:2];
   assign instruction_s2 = instr;
   assign pc_s2          = pc_q;
   assign valid_s2       = vld;

   s1_fetch_perf_counters u_perf (
      .clk           (clk),
      .rst           (rst),
      .counter_rst_i (counter_rst),
      .instr_inc_i   (vld & ~stall),
      .cycle_cnt_o   (cycle_cnt),
      .instr_cnt_o   (instr_cnt)
   );

endmodule

// File: tb/tb_s1_fetch.sv
// Scoreboard bench for s1_fetch: slot-level reference
// model feeds a queue, a negedge monitor compares.
module tb_s1_fetch;

   localparam logic [31:0] RPC = 32'h4000_0000;
   localparam logic [31:0] NOPI = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic [31:0] bios_dout;
   logic [31:0] imem_dout;
   logic        counter_rst;
   logic [31:0] fetch_addr;
   logic [11:0] bios_addra;
   logic [13:0] imem_addrb;
   logic [31:0] instruction_s2;
   logic [31:0] pc_s2;
   logic        valid_s2;
   logic [31:0] cycle_cnt;
   logic [31:0] instr_cnt;

   s1_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .bios_dout       (bios_dout),
      .imem_dout       (imem_dout),
      .counter_rst     (counter_rst),
      .fetch_addr      (fetch_addr),
      .bios_addra      (bios_addra),
      .imem_addrb      (imem_addrb),
      .instruction_s2  (instruction_s2),
      .pc_s2           (pc_s2),
      .valid_s2        (valid_s2),
      .cycle_cnt       (cycle_cnt),
      .instr_cnt       (instr_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] bios_word(input logic [11:0] a);
      if (a == 12'd0) return 32'h0000_0093;
      return {8'hB1, 12'h0A5, a};
   endfunction

   function automatic logic [31:0] imem_word(input logic [13:0] a);
      return {8'h1E, 10'h2C3, a};
   endfunction

   // Memory stand-ins: one-cycle synchronous read.
   always @(posedge clk) begin
      bios_dout <= bios_word(bios_addra);
      imem_dout <= imem_word(imem_addrb);
   end

   typedef struct {
      logic [31:0] fa;
      logic [31:0] ins;
      logic [31:0] pc;
      logic        vld;
      logic [31:0] cyc;
      logic [31:0] icnt;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done = 0;

   // Slot model: what stage 2 holds this cycle.
   localparam int K_BOOT = 0;
   localparam int K_FETCH = 1;
   localparam int K_SQUASH = 2;
   int          m_kind;
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   logic [31:0] m_cyc;
   logic [31:0] m_ins;

   function automatic logic m_valid();
      if (m_kind != K_FETCH) return 1'b0;
      return m_pc[30] || (m_pc[31:28] == 4'h1);
   endfunction

   function automatic logic [31:0] m_instr();
      if (m_kind != K_FETCH) return NOPI;
      if (m_pc[30]) return bios_word(m_pc[13:2]);
      if (m_pc[31:28] == 4'h1) return imem_word(m_pc[15:2]);
      return NOPI;
   endfunction

   function automatic logic [31:0] m_faddr();
      if (m_kind == K_BOOT) return RPC;
      if (m_kind == K_SQUASH) return m_tgt;
      return stall ? m_pc : m_pc + 32'd4;
   endfunction

   task automatic model_reset();
      m_kind = K_BOOT;
      m_pc   = RPC;
      m_tgt  = '0;
      m_cyc  = '0;
      m_ins  = '0;
   endtask

   // Advance one clock edge using the inputs held over it.
   task automatic model_edge();
      logic v;
      v = m_valid();
      if (counter_rst) begin
         m_cyc = '0;
         m_ins = '0;
      end else begin
         m_cyc = m_cyc + 32'd1;
         if (v && !stall) m_ins = m_ins + 32'd1;
      end
      case (m_kind)
         K_BOOT: m_kind = K_FETCH;
         K_FETCH: if (!stall) begin
            if (redirect) begin
               m_kind = K_SQUASH;
               m_tgt  = {redirect_target[31:2], 2'b00};
            end
            m_pc = m_pc + 32'd4;
         end
         default: if (!stall) begin
            m_pc   = m_tgt;
            m_kind = K_FETCH;
         end
      endcase
   endtask

   task automatic cyc(input logic st, input logic rd,
                      input logic [31:0] tg, input logic cr,
                      input logic rs);
      exp_t e;
      @(posedge clk);
      #1;
      if (!rst) model_edge();
      rst             = rs;
      stall           = st;
      redirect        = rd;
      redirect_target = tg;
      counter_rst     = cr;
      if (rs) model_reset();
      e.fa   = m_faddr();
      e.ins  = m_instr();
      e.pc   = m_pc;
      e.vld  = m_valid();
      e.cyc  = m_cyc;
      e.icnt = m_ins;
      q.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got %08h expected %08h",
                  nm, $time, act, exp);
      end
   endtask

   // Monitor: pop one expectation per cycle and compare.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("fetch_addr", fetch_addr, e.fa);
            chk("bios_addra", {20'd0, bios_addra}, {20'd0, e.fa[13:2]});
            chk("imem_addrb", {18'd0, imem_addrb}, {18'd0, e.fa[15:2]});
            chk("pc_s2", pc_s2, e.pc);
            chk("valid_s2", {31'd0, valid_s2}, {31'd0, e.vld});
            if (e.vld) chk("instruction_s2", instruction_s2, e.ins);
            else chk("bubble_nop", instruction_s2, NOPI);
            chk("cycle_cnt", cycle_cnt, e.cyc);
            chk("instr_cnt", instr_cnt, e.icnt);
         end
      end
   end

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      case ($urandom_range(0, 3))
         0: t = 32'h4000_0000 | $urandom_range(0, 32'h3FFF);
         1: t = 32'h1000_0000 | $urandom_range(0, 32'hFFFF);
         2: t = 32'h8000_0000 | $urandom_range(0, 32'hFFFF);
         default: t = $urandom;
      endcase
      return t;
   endfunction

   initial begin
      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_target = '0;
      counter_rst = 1'b0;
      model_reset();
      repeat (2) cyc(0, 0, 0, 0, 1);
      // Boot, then sequential BIOS run up to 4000_0010.
      repeat (5) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 32'h1000_0000, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      // Stall in RUN with redirect asserted: ignored.
      repeat (3) cyc(1, 1, 32'h4000_0200, 0, 0);
      cyc(0, 1, 32'h4000_0103, 0, 0);
      // Stall while squashing; pending target must survive.
      cyc(1, 1, 32'h1000_0040, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      // Unmapped region yields bubbles.
      cyc(0, 1, 32'h8000_0000, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 32'h4000_0000, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0);
      // Clear concurrent with increment.
      cyc(0, 0, 0, 1, 0);
      repeat (2) cyc(0, 0, 0, 0, 0);
      // Async reset while in the squash slot.
      cyc(0, 1, 32'h1000_0100, 0, 0);
      cyc(0, 0, 0, 0, 1);
      repeat (4) cyc(0, 0, 0, 0, 0);
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         cyc($urandom_range(0, 3) == 0,
             $urandom_range(0, 4) == 0,
             rand_target(),
             $urandom_range(0, 40) == 0,
             $urandom_range(0, 120) == 0);
      end
      cyc(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left %0d expected 0",
                  q.size());
      end
      done = 1;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
